// File: rtl/s1_mem_pkg.sv
// Shared types and constants for the memory access controller.
package s1_mem_pkg;

   // Controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Response error codes
   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_BUS      = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   // Access size decode of fn4[1:0]; 3 also means word
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_align_chk.sv
// Flags accesses whose address is not a multiple of the access size.
module mem_align_chk
   import s1_mem_pkg::*;
(
   input  logic [1:0] addr,
   input  logic [3:0] fn4,
   output logic       misaligned
);

   logic [1:0] size;
   logic       unused_fn4;

   assign size       = fn4[1:0];
   assign unused_fn4 = ^fn4[3:2];

   // Halfwords need addr[0]==0, words need addr[1:0]==0
   always_comb begin
      misaligned = 1'b0;
      if (size == SZ_HALF) begin
         misaligned = addr[0];
      end else if (size >= SZ_WORD) begin
         misaligned = (addr != 2'b00);
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: accepts one pipeline request, runs a single
// bus transfer with timeout, and holds the response until it is consumed.
module mem_access_ctrl
   import s1_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          MISALIGN_TRAP  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_fn4,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_mask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [3:0]  resp_fn4,
   output logic [1:0]  resp_addr_low,
   output logic [1:0]  resp_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [31:0] bus_rdata
);

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       misaligned;
   logic       trap;

   mem_align_chk u_align (
      .addr       (req_addr[1:0]),
      .fn4        (req_fn4),
      .misaligned (misaligned)
   );

   assign trap = MISALIGN_TRAP && misaligned;

   // Controller FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         wait_cnt      <= '0;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         resp_fn4      <= '0;
         resp_addr_low <= '0;
         resp_err      <= ERR_OK;
         bus_req       <= 1'b0;
         bus_we        <= 1'b0;
         bus_addr      <= '0;
         bus_wdata     <= '0;
         bus_be        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready     <= 1'b0;
                  resp_fn4      <= req_fn4;
                  resp_addr_low <= req_addr[1:0];
                  resp_rdata    <= '0;
                  if (trap) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_MISALIGN;
                  end else begin
                     state     <= ST_BUS;
                     wait_cnt  <= '0;
                     bus_req   <= 1'b1;
                     bus_we    <= req_we;
                     bus_addr  <= {req_addr[31:2], 2'b00};
                     bus_wdata <= req_wdata;
                     bus_be    <= req_we ? req_mask : 4'b1111;
                  end
               end
            end
            ST_BUS: begin
               // bus_err has priority over a simultaneous bus_ack
               if (bus_err) begin
                  state      <= ST_RESP;
                  bus_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_BUS;
               end else if (bus_ack) begin
                  state      <= ST_RESP;
                  bus_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= ERR_OK;
                  resp_rdata <= bus_we ? 32'd0 : bus_rdata;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_cnt + 8'd1 == TIMEOUT_LIM) begin
                     state      <= ST_RESP;
                     bus_req    <= 1'b0;
                     resp_valid <= 1'b1;
                     resp_err   <= ERR_TIMEOUT;
                  end
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state      <= ST_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               bus_req    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus wait cycles before a timeout error, range 1..255.
REQ-002 SHALL have parameter MISALIGN_TRAP, default 1: 1 = misaligned access is reported as an error, 0 = address low bits ignored for the bus.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  pipeline access request.
REQ-006 req_ready  out  1  request accepted this cycle when req_valid is also high.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_fn4  in  4  load/store funct; size = fn4[1:0] (0 byte, 1 half, 2/3 word), fn4[3] = sign-extend.
REQ-010 req_wdata  in  32  lane-aligned store data, big-endian lanes (byte 0 = bits 31:24).
REQ-011 req_mask  in  4  store byte enables; bit 3 = lane 31:24.
REQ-012 resp_valid  out  1  response available.
REQ-013 resp_ready  in  1  consumer accepts the response.
REQ-014 resp_rdata  out  32  raw bus word, fed to the load-format stage unmodified.
REQ-015 resp_fn4, resp_addr_low  out  4, 2  the request's fn4 and addr[1:0], held with the response.
REQ-016 resp_err  out  2  0 ok, 1 misaligned, 2 bus error, 3 timeout.
REQ-017 bus_req, bus_we  out  1, 1  bus strobe and write flag.
REQ-018 bus_addr, bus_wdata, bus_be  out  32, 32, 4  word address ({addr[31:2],2'b00}), data, byte enables.
REQ-019 bus_ack, bus_err  in  1, 1  single-cycle completion and fault strobes.
REQ-020 bus_rdata  in  32  read data, valid when bus_ack is high.

Function
REQ-021 SHALL implement FSM states IDLE, BUS, RESP.
REQ-022 req_ready SHALL be high only in IDLE; a transfer is req_valid&&req_ready.
REQ-023 On a transfer the block SHALL register we, addr, fn4, wdata and mask.
REQ-024 On a transfer, if MISALIGN_TRAP=1 and (size==1 && addr[0]) or (size>=2 && addr[1:0]!=0), the block SHALL go to RESP with resp_err=1 and SHALL NOT assert bus_req.
REQ-025 On any other transfer the block SHALL go to BUS; bus_req SHALL be high from the next cycle and held, with stable address, data and enables, until completion.
REQ-026 bus_be SHALL be the registered mask for stores; for loads it SHALL be 4'b1111.
REQ-027 Completion in BUS: bus_err high -> RESP, err=2; else bus_ack high -> capture bus_rdata, RESP, err=0.
REQ-028 If bus_err and bus_ack are high together, bus_err SHALL win.
REQ-029 An 8-bit wait counter SHALL clear on entering BUS and increment each BUS cycle without completion.
REQ-030 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL drop bus_req, go to RESP with err=3, and ignore any later bus_ack.
REQ-031 bus_req SHALL be low in the cycle after completion, so minimum load latency is 3 cycles (accept, bus, resp).
REQ-032 resp_valid SHALL be high exactly in RESP; all resp_* outputs SHALL be stable until resp_valid&&resp_ready, then the FSM SHALL return to IDLE.
REQ-033 The block SHALL NOT accept a new request in the cycle its response is consumed.
REQ-034 resp_rdata SHALL be 0 for stores and for errored accesses.

Reset
REQ-035 With rst_n low at a clock edge, state SHALL be IDLE, the wait counter 0, and every output 0 except req_ready, which SHALL be 1.
REQ-036 A reset during BUS SHALL deassert bus_req at that edge; a late bus_ack SHALL then be ignored.

Structure
REQ-037 The state enum, the resp_err codes and the size decode constants SHALL live in the shared package s1_mem_pkg.
REQ-038 The alignment check SHALL be a sub-module, mem_align_chk (inputs addr[1:0] and fn4, output misaligned).

Verification
REQ-039 Byte load, addr 0x103, bus_ack after 2 wait cycles with rdata 0x11223344 -> resp_rdata 0x11223344, resp_addr_low 3, err 0, bus_be 4'b1111.
REQ-040 Half store, addr 0x202, mask 0011, wdata 0x0000BEEF, ack on the first cycle -> bus_addr 0x200, bus_be 0011, bus_we 1, err 0.
REQ-041 Word load at 0x301 with MISALIGN_TRAP=1 -> bus_req never high, resp_err 1 on the next cycle.
REQ-042 TIMEOUT_CYCLES=4 with no ack -> bus_req high for 4 cycles, err 3; an ack injected afterwards is ignored.
REQ-043 bus_ack and bus_err high together -> err 2; resp_ready held low for 5 cycles -> outputs stable, req_ready low throughout.
REQ-044 rst_n low during the second BUS cycle -> next cycle bus_req 0, req_ready 1, resp_valid 0.
